ccd_capture: RTL and testbench
==============================

# ccd_capture

Sensor-side capture stage that sits directly upstream of the image processing pipeline's grayscale converter. It registers the raw 12-bit Bayer stream from the CMOS sensor, gates it to whole frames under start/stop control, and emits the pixel data, pixel valid, and column/row coordinates consumed as `iDATA`, `iDVAL`, `iX_Cont` and `iY_Cont` by the image processing block. It also counts completed frames for the status display.

## Interface
- `COLUMN_WIDTH`, default 1280: active pixels per line; the column counter wraps at this value.

- `iCLK`  in  1  pixel clock; single clock domain.
- `iRST`  in  1  reset; synchronous, active-high.
- `iDATA`  in  12  raw sensor pixel.
- `iFVAL`  in  1  sensor frame valid.
- `iLVAL`  in  1  sensor line valid.
- `iSTART`  in  1  start-capture pulse.
- `iEND`  in  1  stop-capture pulse.
- `oDATA`  out  12  captured pixel.
- `oDVAL`  out  1  `oDATA` valid.
- `oX_Cont`  out  16  column of the pixel on `oDATA`.
- `oY_Cont`  out  16  row of the pixel on `oDATA`.
- `oFrame_Cont`  out  32  completed captured frames, wrapping.
- `oBUSY`  out  1  high whenever the state is not IDLE.

## Operation
- **Stage 1:** `iDATA`, `iFVAL` and `iLVAL` are registered into `d_DATA`, `d_FVAL` and `d_LVAL`. `p_FVAL` holds the previous `d_FVAL`.
- **Edge detects:** `fval_rise = d_FVAL & ~p_FVAL`. `fval_fall = ~d_FVAL & p_FVAL`.
- **State machine:** IDLE, ARMED, RUN, STOPPING.
  - IDLE -> ARMED on `iSTART`.
  - ARMED -> RUN on `fval_rise`.
  - RUN -> STOPPING on `iEND`.
  - STOPPING -> IDLE on `fval_fall`.
  - ARMED -> IDLE on `iEND`.
- **Simultaneous events:**
  - `iSTART` and `iEND` in the same cycle: `iEND` wins.
  - `iSTART` in ARMED, RUN or STOPPING is ignored.
  - `iEND` in IDLE or STOPPING is ignored.
- **Capture window:** `capture` is true when any of the following holds:
  - state is RUN or STOPPING;
  - state is ARMED and `fval_rise` is high.
- **Stage 2 (output registers):**
  - `oDVAL <= capture & d_FVAL & d_LVAL`.
  - `oDATA <= d_DATA` every cycle. `oDATA` is don't-care when `oDVAL=0`.
- **Coordinates:**
  - On `fval_rise` inside the capture window, the internal column and row counters clear to 0.
  - Each valid pixel loads `oX_Cont`/`oY_Cont` from the counters, then the column counter increments.
  - When the column counter reaches `COLUMN_WIDTH-1`, the next valid pixel moves it to 0 and increments the row counter.
  - The row counter wraps modulo 2^16.
  - `oX_Cont`/`oY_Cont` hold their values while `oDVAL=0`.
  - The `LVAL` edges do not reset the column counter; line length is set by `COLUMN_WIDTH`.
- **Frame counter:** `oFrame_Cont` increments by 1 on `fval_fall` when the state is RUN or STOPPING. It wraps modulo 2^32.
- **A frame is never partially captured.**
  - Capture starts only on a frame-valid rising edge.
  - A stop request finishes the frame in progress.

## Timing
- **Latency:** a pixel sampled from `iDATA` at edge N appears on `oDATA`/`oDVAL`/`oX_Cont`/`oY_Cont` after edge N+1. The latency is 2 cycles, measured from input setup to output valid.
- **Throughput:** one pixel per clock. There is no backpressure.
- **Frame counter timing:** `oFrame_Cont` updates after the edge at which `fval_fall` is high, 2 cycles after `iFVAL` falls.
- **Control inputs:** `iSTART` and `iEND` are sampled directly, with no stage-1 register. The state changes after the edge where the pulse is high.
- **Reset values (`iRST` high at an edge):**
  - state = IDLE.
  - All outputs = 0.
  - `d_DATA`, `d_LVAL`, counters = 0.
  - `d_FVAL` and `p_FVAL` = 1. This suppresses a false `fval_rise`, so a frame already in progress when reset releases is never captured.
- **Reset mid-frame:** `oDVAL` drops in the cycle after the reset edge. `oFrame_Cont` is not incremented for the aborted frame.

## Test plan
- **Basic capture:** reset; pulse `iSTART`; drive 3 frames of 4 lines × 1280 pixels with `iDATA` = column index. Required: `oDVAL` is high for exactly 15360 cycles, `oX_Cont` runs 0..1279 and `oY_Cont` 0..3 in each frame, `oFrame_Cont` = 3, `oDATA` equals the input delayed by 2 cycles.
- **Arm mid-frame:** pulse `iSTART` while `iFVAL` is high. Required: no `oDVAL` until the next `iFVAL` rise; the first output pixel has X=0, Y=0.
- **Stop mid-frame:** pulse `iEND` at line 2 of frame 1. Required: frame 1 completes (5120 valid pixels), `oFrame_Cont` = 1, the state returns to IDLE, and frame 2 produces no `oDVAL`.
- **Simultaneous events:** in ARMED, assert `iSTART` and `iEND` together. Required: the state goes to IDLE and `oBUSY` = 0 on the next cycle.
- **Reset with frame active:** hold `iFVAL` = 1 through reset release with the state re-armed. Required: no `fval_rise` and no capture until `iFVAL` goes low then high.
- **Wrap:** set `COLUMN_WIDTH` = 4 and drive a 10-pixel line. Required: `oX_Cont` sequence 0,1,2,3,0,1,2,3,0,1 with `oY_Cont` incrementing at each wrap.

Source files
------------

// File: rtl/ccd_capture.sv
// ---------------------------------------------------------------------------
// ccd_capture
//
// Sensor-side capture stage in front of the grayscale converter. It registers
// the raw 12-bit Bayer stream and gates it to whole frames under start/stop
// control. It emits pixel data, pixel valid and column/row coordinates, and
// counts completed captured frames.
//
// Parameters:
//   COLUMN_WIDTH  active pixels per line; the column counter wraps here
//
// Ports:
//   iCLK         in   1   pixel clock (single domain)
//   iRST         in   1   synchronous active-high reset
//   iDATA        in  12   raw sensor pixel
//   iFVAL        in   1   sensor frame valid
//   iLVAL        in   1   sensor line valid
//   iSTART       in   1   start-capture pulse (sampled directly)
//   iEND         in   1   stop-capture pulse (sampled directly)
//   oDATA        out 12   captured pixel (don't-care while oDVAL=0)
//   oDVAL        out  1   oDATA valid
//   oX_Cont      out 16   column of the pixel on oDATA
//   oY_Cont      out 16   row of the pixel on oDATA
//   oFrame_Cont  out 32   completed captured frames, wrapping
//   oBUSY        out  1   high whenever the capture FSM is not idle
// ---------------------------------------------------------------------------
module ccd_capture #(
  parameter int COLUMN_WIDTH = 1280
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [11:0] iDATA,
  input  logic        iFVAL,
  input  logic        iLVAL,
  input  logic        iSTART,
  input  logic        iEND,
  output logic [11:0] oDATA,
  output logic        oDVAL,
  output logic [15:0] oX_Cont,
  output logic [15:0] oY_Cont,
  output logic [31:0] oFrame_Cont,
  output logic        oBUSY
);

  localparam logic [15:0] LAST_COL = 16'(COLUMN_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    RUN      = 2'd2,
    STOPPING = 2'd3
  } state_t;

  // Stage-1 registers
  logic [11:0] dData_r;
  logic        dFval_r;
  logic        dLval_r;
  logic        pFval_r;

  // Edge detects and FSM
  logic        fvalRise_s;
  logic        fvalFall_s;
  state_t      state_r;
  state_t      nextState_s;
  logic        capture_s;
  logic        inFrame_s;
  logic        pixelValid_s;

  // Coordinate counters
  logic [15:0] colCnt_r;
  logic [15:0] rowCnt_r;
  logic [15:0] colBase_s;
  logic [15:0] rowBase_s;
  logic [15:0] colStep_s;
  logic [15:0] rowStep_s;

  // Output registers
  logic [11:0] data_r;
  logic        dval_r;
  logic [15:0] xCont_r;
  logic [15:0] yCont_r;
  logic [31:0] frameCnt_r;
  logic        busy_r;

  // Stage 1: register the sensor stream. The FVAL history resets high so a
  // frame already in flight at reset release never looks like a rising edge.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      dData_r <= 12'd0;
      dFval_r <= 1'b1;
      dLval_r <= 1'b0;
      pFval_r <= 1'b1;
    end else begin
      dData_r <= iDATA;
      dFval_r <= iFVAL;
      dLval_r <= iLVAL;
      pFval_r <= dFval_r;
    end
  end

  // Frame-valid edge detection on the registered stream
  always_comb begin
    fvalRise_s = dFval_r & ~pFval_r;
    fvalFall_s = ~dFval_r & pFval_r;
  end

  // FSM state register
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // FSM next-state logic; iEND has priority over iSTART when both are high
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (iSTART && !iEND) begin
          nextState_s = ARMED;
        end else begin
          nextState_s = IDLE;
        end
      end
      ARMED: begin
        if (iEND) begin
          nextState_s = IDLE;
        end else if (fvalRise_s) begin
          nextState_s = RUN;
        end else begin
          nextState_s = ARMED;
        end
      end
      RUN: begin
        if (iEND) begin
          nextState_s = STOPPING;
        end else begin
          nextState_s = RUN;
        end
      end
      STOPPING: begin
        if (fvalFall_s) begin
          nextState_s = IDLE;
        end else begin
          nextState_s = STOPPING;
        end
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // FSM outputs: capture window opens on the first frame edge seen while armed
  always_comb begin
    inFrame_s    = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      IDLE: begin
        inFrame_s = 1'b0;
        capture_s = 1'b0;
      end
      ARMED: begin
        inFrame_s = 1'b0;
        capture_s = fvalRise_s;
      end
      RUN, STOPPING: begin
        inFrame_s = 1'b1;
        capture_s = 1'b1;
      end
      default: begin
        inFrame_s = 1'b0;
        capture_s = 1'b0;
      end
    endcase
    pixelValid_s = capture_s & dFval_r & dLval_r;
  end

  // Coordinate arithmetic: a captured frame edge restarts at (0,0) in the
  // same cycle, so a pixel arriving with that edge is tagged (0,0).
  always_comb begin
    if (fvalRise_s && capture_s) begin
      colBase_s = 16'd0;
      rowBase_s = 16'd0;
    end else begin
      colBase_s = colCnt_r;
      rowBase_s = rowCnt_r;
    end
    if (colBase_s == LAST_COL) begin
      colStep_s = 16'd0;
      rowStep_s = rowBase_s + 16'd1;
    end else begin
      colStep_s = colBase_s + 16'd1;
      rowStep_s = rowBase_s;
    end
  end

  // Column/row counters advance once per valid pixel; LVAL edges are ignored
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      colCnt_r <= 16'd0;
      rowCnt_r <= 16'd0;
    end else if (pixelValid_s) begin
      colCnt_r <= colStep_s;
      rowCnt_r <= rowStep_s;
    end else begin
      colCnt_r <= colBase_s;
      rowCnt_r <= rowBase_s;
    end
  end

  // Stage 2: pixel, valid and coordinate output registers
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      data_r  <= 12'd0;
      dval_r  <= 1'b0;
      xCont_r <= 16'd0;
      yCont_r <= 16'd0;
    end else begin
      data_r <= dData_r;
      dval_r <= pixelValid_s;
      if (pixelValid_s) begin
        xCont_r <= colBase_s;
        yCont_r <= rowBase_s;
      end else begin
        xCont_r <= xCont_r;
        yCont_r <= yCont_r;
      end
    end
  end

  // Completed-frame counter: only frames that closed while capturing count
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      frameCnt_r <= 32'd0;
    end else if (fvalFall_s && inFrame_s) begin
      frameCnt_r <= frameCnt_r + 32'd1;
    end else begin
      frameCnt_r <= frameCnt_r;
    end
  end

  // Busy flag registered from the next state so it tracks the state register
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (nextState_s != IDLE);
    end
  end

  assign oDATA       = data_r;
  assign oDVAL       = dval_r;
  assign oX_Cont     = xCont_r;
  assign oY_Cont     = yCont_r;
  assign oFrame_Cont = frameCnt_r;
  assign oBUSY       = busy_r;

endmodule

// File: tb/tb_ccd_capture.sv
module tb_ccd_capture;

  logic        iCLK;
  logic        iRST;
  // main instance (COLUMN_WIDTH = 1280)
  logic [11:0] iDATA;
  logic        iFVAL, iLVAL, iSTART, iEND;
  logic [11:0] oDATA;
  logic        oDVAL;
  logic [15:0] oX_Cont, oY_Cont;
  logic [31:0] oFrame_Cont;
  logic        oBUSY;
  // narrow instance (COLUMN_WIDTH = 4)
  logic [11:0] wDATA;
  logic        wFVAL, wLVAL, wSTART, wEND;
  logic [11:0] wODATA;
  logic        wODVAL;
  logic [15:0] wOX, wOY;
  logic [31:0] wOFrame;
  logic        wOBUSY;

  int nChecks = 0;
  int nErrors = 0;
  int cyc = 0;
  int dvalCount = 0;

  typedef struct {
    logic [11:0] data;
    logic [15:0] x;
    logic [15:0] y;
    int          edgeN;
  } exp_t;
  exp_t sbq[$];
  exp_t monE;

  typedef struct {
    logic        start;
    logic        stop;
    logic        fval;
    logic        lval;
    logic [11:0] data;
    logic        expDval;
    logic [11:0] expData;
    logic [15:0] expX;
    logic [15:0] expY;
    logic [31:0] expFrame;
    logic        expBusy;
  } vec_t;
  vec_t vecs[16];

  ccd_capture #(.COLUMN_WIDTH(1280)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iFVAL(iFVAL), .iLVAL(iLVAL),
    .iSTART(iSTART), .iEND(iEND), .oDATA(oDATA), .oDVAL(oDVAL),
    .oX_Cont(oX_Cont), .oY_Cont(oY_Cont), .oFrame_Cont(oFrame_Cont), .oBUSY(oBUSY)
  );

  ccd_capture #(.COLUMN_WIDTH(4)) wDut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(wDATA), .iFVAL(wFVAL), .iLVAL(wLVAL),
    .iSTART(wSTART), .iEND(wEND), .oDATA(wODATA), .oDVAL(wODVAL),
    .oX_Cont(wOX), .oY_Cont(wOY), .oFrame_Cont(wOFrame), .oBUSY(wOBUSY)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every valid output pixel must match the oldest expectation
  always @(negedge iCLK) begin
    if (oDVAL === 1'b1) begin
      dvalCount++;
      if (sbq.size() == 0) begin
        nChecks++;
        nErrors++;
        $display("FAIL unexpected_dval: actual oDVAL=1 x=%0d y=%0d required oDVAL=0 (t=%0t)",
                 oX_Cont, oY_Cont, $time);
      end else begin
        monE = sbq.pop_front();
        chk("pix_data", 32'(oDATA), 32'(monE.data));
        chk("pix_x", 32'(oX_Cont), 32'(monE.x));
        chk("pix_y", 32'(oY_Cont), 32'(monE.y));
        chk("pix_latency_edge", 32'(cyc), 32'(monE.edgeN + 1));
      end
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic sendPixel(input logic [11:0] d, input logic fv, input logic lv,
                           input bit cap, input int x, input int y);
    exp_t e;
    iDATA = d;
    iFVAL = fv;
    iLVAL = lv;
    if (cap && fv && lv) begin
      e.data  = d;
      e.x     = 16'(x);
      e.y     = 16'(y);
      e.edgeN = cyc + 1;
      sbq.push_back(e);
    end
    tick();
  endtask

  // One frame: FVAL low porch, FVAL high, `lines` lines of 1280 pixels with
  // data = column index, LVAL gaps, then FVAL low. Optional start/stop pulses
  // at column 0 of the given line.
  task automatic sendFrame(input int lines, input bit cap, input int startLine, input int endLine);
    iSTART = 1'b0;
    iEND   = 1'b0;
    iFVAL  = 1'b0;
    iLVAL  = 1'b0;
    repeat (3) tick();
    iFVAL = 1'b1;
    repeat (2) tick();
    for (int l = 0; l < lines; l++) begin
      for (int c = 0; c < 1280; c++) begin
        iSTART = (l == startLine) && (c == 0);
        iEND   = (l == endLine) && (c == 0);
        sendPixel(12'(c), 1'b1, 1'b1, cap, c, l);
      end
      iSTART = 1'b0;
      iEND   = 1'b0;
      iLVAL  = 1'b0;
      repeat (4) tick();
    end
    iFVAL = 1'b0;
    repeat (3) tick();
  endtask

  task automatic doReset(input int n);
    iRST = 1'b1;
    repeat (n) tick();
    iRST = 1'b0;
  endtask

  function automatic vec_t mkVec(input logic st, input logic en, input logic fv, input logic lv,
                                 input logic [11:0] d, input logic eDv, input logic [11:0] eD,
                                 input logic [15:0] eX, input logic [15:0] eY,
                                 input logic [31:0] eF, input logic eB);
    vec_t v;
    v.start = st; v.stop = en; v.fval = fv; v.lval = lv; v.data = d;
    v.expDval = eDv; v.expData = eD; v.expX = eX; v.expY = eY;
    v.expFrame = eF; v.expBusy = eB;
    return v;
  endfunction

  initial begin
    // Wrap table for the COLUMN_WIDTH=4 instance. Expected fields describe the
    // outputs just after the edge that samples that row's inputs.
    vecs[0]  = mkVec(1'b1, 1'b0, 1'b0, 1'b0, 12'd0,   1'b0, 12'd0,   16'd0, 16'd0, 32'd0, 1'b1);
    vecs[1]  = mkVec(1'b0, 1'b0, 1'b0, 1'b0, 12'd0,   1'b0, 12'd0,   16'd0, 16'd0, 32'd0, 1'b1);
    vecs[2]  = mkVec(1'b0, 1'b0, 1'b1, 1'b1, 12'd100, 1'b0, 12'd0,   16'd0, 16'd0, 32'd0, 1'b1);
    vecs[3]  = mkVec(1'b0, 1'b0, 1'b1, 1'b1, 12'd101, 1'b1, 12'd100, 16'd0, 16'd0, 32'd0, 1'b1);
    vecs[4]  = mkVec(1'b0, 1'b0, 1'b1, 1'b1, 12'd102, 1'b1, 12'd101, 16'd1, 16'd0, 32'd0, 1'b1);
    vecs[5]  = mkVec(1'b0, 1'b0, 1'b1, 1'b1, 12'd103, 1'b1, 12'd102, 16'd2, 16'd0, 32'd0, 1'b1);
    vecs[6]  = mkVec(1'b0, 1'b0, 1'b1, 1'b1, 12'd104, 1'b1, 12'd103, 16'd3, 16'd0, 32'd0, 1'b1);
    vecs[7]  = mkVec(1'b0, 1'b0, 1'b1, 1'b1, 12'd105, 1'b1, 12'd104, 16'd0, 16'd1, 32'd0, 1'b1);
    vecs[8]  = mkVec(1'b0, 1'b0, 1'b1, 1'b1, 12'd106, 1'b1, 12'd105, 16'd1, 16'd1, 32'd0, 1'b1);
    vecs[9]  = mkVec(1'b0, 1'b0, 1'b1, 1'b1, 12'd107, 1'b1, 12'd106, 16'd2, 16'd1, 32'd0, 1'b1);
    vecs[10] = mkVec(1'b0, 1'b0, 1'b1, 1'b1, 12'd108, 1'b1, 12'd107, 16'd3, 16'd1, 32'd0, 1'b1);
    vecs[11] = mkVec(1'b0, 1'b0, 1'b1, 1'b1, 12'd109, 1'b1, 12'd108, 16'd0, 16'd2, 32'd0, 1'b1);
    vecs[12] = mkVec(1'b0, 1'b1, 1'b1, 1'b0, 12'd0,   1'b1, 12'd109, 16'd1, 16'd2, 32'd0, 1'b1);
    vecs[13] = mkVec(1'b0, 1'b0, 1'b0, 1'b0, 12'd0,   1'b0, 12'd0,   16'd1, 16'd2, 32'd0, 1'b1);
    vecs[14] = mkVec(1'b0, 1'b0, 1'b0, 1'b0, 12'd0,   1'b0, 12'd0,   16'd1, 16'd2, 32'd1, 1'b0);
    vecs[15] = mkVec(1'b0, 1'b0, 1'b0, 1'b0, 12'd0,   1'b0, 12'd0,   16'd1, 16'd2, 32'd1, 1'b0);

    iRST = 1'b1;
    iDATA = 12'd0; iFVAL = 1'b0; iLVAL = 1'b0; iSTART = 1'b0; iEND = 1'b0;
    wDATA = 12'd0; wFVAL = 1'b0; wLVAL = 1'b0; wSTART = 1'b0; wEND = 1'b0;
    doReset(3);

    // Reset state
    chk("rst_dval", 32'(oDVAL), 32'd0);
    chk("rst_data", 32'(oDATA), 32'd0);
    chk("rst_x", 32'(oX_Cont), 32'd0);
    chk("rst_y", 32'(oY_Cont), 32'd0);
    chk("rst_frame", oFrame_Cont, 32'd0);
    chk("rst_busy", 32'(oBUSY), 32'd0);

    // Column wrap on the narrow instance
    for (int i = 0; i < 16; i++) begin
      wSTART = vecs[i].start;
      wEND   = vecs[i].stop;
      wFVAL  = vecs[i].fval;
      wLVAL  = vecs[i].lval;
      wDATA  = vecs[i].data;
      tick();
      chk($sformatf("wrap_dval[%0d]", i), 32'(wODVAL), 32'(vecs[i].expDval));
      if (vecs[i].expDval)
        chk($sformatf("wrap_data[%0d]", i), 32'(wODATA), 32'(vecs[i].expData));
      chk($sformatf("wrap_x[%0d]", i), 32'(wOX), 32'(vecs[i].expX));
      chk($sformatf("wrap_y[%0d]", i), 32'(wOY), 32'(vecs[i].expY));
      chk($sformatf("wrap_frame[%0d]", i), wOFrame, vecs[i].expFrame);
      chk($sformatf("wrap_busy[%0d]", i), 32'(wOBUSY), 32'(vecs[i].expBusy));
    end
    wSTART = 1'b0;
    wEND   = 1'b0;

    // Basic capture: 3 frames of 4 x 1280
    iSTART = 1'b1;
    tick();
    iSTART = 1'b0;
    chk("basic_busy_armed", 32'(oBUSY), 32'd1);
    dvalCount = 0;
    repeat (3) sendFrame(4, 1'b1, -1, -1);
    chk("basic_dval_count", 32'(dvalCount), 32'd15360);
    chk("basic_frames", oFrame_Cont, 32'd3);
    chk("basic_sb_drained", 32'(sbq.size()), 32'd0);

    // Stop mid-frame: frame 1 finishes, frame 2 is ignored
    doReset(2);
    iSTART = 1'b1;
    tick();
    iSTART = 1'b0;
    dvalCount = 0;
    sendFrame(4, 1'b1, -1, 2);
    chk("stop_dval_count", 32'(dvalCount), 32'd5120);
    chk("stop_frames", oFrame_Cont, 32'd1);
    chk("stop_busy_idle", 32'(oBUSY), 32'd0);
    sendFrame(4, 1'b0, -1, -1);
    chk("stop_no_second_frame", 32'(dvalCount), 32'd5120);
    chk("stop_frames_after", oFrame_Cont, 32'd1);
    chk("stop_sb_drained", 32'(sbq.size()), 32'd0);

    // Arm mid-frame: current frame skipped, next frame captured from (0,0)
    doReset(2);
    dvalCount = 0;
    sendFrame(2, 1'b0, 1, -1);
    chk("arm_busy", 32'(oBUSY), 32'd1);
    chk("arm_no_early_dval", 32'(dvalCount), 32'd0);
    sendFrame(2, 1'b1, -1, -1);
    chk("arm_dval_count", 32'(dvalCount), 32'd2560);
    chk("arm_frames", oFrame_Cont, 32'd1);
    chk("arm_sb_drained", 32'(sbq.size()), 32'd0);

    // Simultaneous start/stop
    doReset(2);
    iSTART = 1'b1; iEND = 1'b1;
    tick();
    chk("sim_idle_busy", 32'(oBUSY), 32'd0);
    iEND = 1'b0;
    tick();
    iSTART = 1'b0;
    chk("sim_armed_busy", 32'(oBUSY), 32'd1);
    iSTART = 1'b1; iEND = 1'b1;
    tick();
    iSTART = 1'b0; iEND = 1'b0;
    chk("sim_armed_to_idle", 32'(oBUSY), 32'd0);

    // Reset released with a frame in progress, then re-armed
    iFVAL = 1'b1; iLVAL = 1'b0;
    tick();
    doReset(2);
    iSTART = 1'b1;
    tick();
    iSTART = 1'b0;
    chk("rstfr_busy", 32'(oBUSY), 32'd1);
    dvalCount = 0;
    for (int l = 0; l < 2; l++) begin
      for (int c = 0; c < 1280; c++) sendPixel(12'(c), 1'b1, 1'b1, 1'b0, c, l);
      iLVAL = 1'b0;
      repeat (4) tick();
    end
    chk("rstfr_no_capture", 32'(dvalCount), 32'd0);
    sendFrame(2, 1'b1, -1, -1);
    chk("rstfr_dval_count", 32'(dvalCount), 32'd2560);
    chk("rstfr_frames", oFrame_Cont, 32'd1);
    chk("rstfr_sb_drained", 32'(sbq.size()), 32'd0);

    // Reset in the middle of a captured frame
    iFVAL = 1'b0; iLVAL = 1'b0;
    repeat (3) tick();
    iFVAL = 1'b1;
    repeat (2) tick();
    for (int c = 0; c < 100; c++) sendPixel(12'(c), 1'b1, 1'b1, 1'b1, c, 0);
    iRST = 1'b1;
    iDATA = 12'd100;
    tick();
    chk("rstmid_dval_drop", 32'(oDVAL), 32'd0);
    chk("rstmid_pending", 32'(sbq.size()), 32'd1);
    sbq.delete();
    iRST = 1'b0;
    repeat (10) tick();
    iFVAL = 1'b0; iLVAL = 1'b0;
    repeat (4) tick();
    chk("rstmid_frames", oFrame_Cont, 32'd0);
    chk("rstmid_busy", 32'(oBUSY), 32'd0);

    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
